// File: rtl/cargador_instrucciones_pkg.sv
// Shared definitions for the instruction loader: FSM encoding and word geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkg_cargador;

   // Default instruction memory depth in 32-bit words.
   localparam int PROF_MEM_DEF      = 64;
   localparam int BYTES_POR_PALABRA = 4;

   typedef enum logic [1:0] {
      REPOSO    = 2'd0,
      CARGA     = 2'd1,
      ESCRITURA = 2'd2,
      EJECUCION = 2'd3
   } estado_t;

endpackage

// File: rtl/cargador_instrucciones_ensamblador.sv
// Big-endian byte-to-word shifter: first byte of a word ends up in [31:24].
// Latency: palabra_lista is combinational on the 4th shift; storage updates on the next edge.
// Backpressure: none; the caller only asserts desplazar on an accepted byte.
//
// Ports:
//   CLK, RST_N     clock, async active-low reset
//   desplazar      shift byte_in in (one accepted byte)
//   limpiar        discard any partial word, count back to 0
//   byte_in        stream byte
//   palabra        word as it would read after shifting byte_in in
//   palabra_lista  this shift completes a word
module ensamblador_palabra
   import pkg_cargador::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        desplazar,
   input  logic        limpiar,
   input  logic [7:0]  byte_in,
   output logic [31:0] palabra,
   output logic        palabra_lista
);

   localparam logic [1:0] C_ULTIMO = 2'(BYTES_POR_PALABRA - 1);

   // The three older bytes of the 32-bit shift register are stored here; the
   // newest byte is taken straight from byte_in so the top level can latch the
   // complete word on the same edge that accepts the 4th byte.
   logic [23:0] r_bytes;
   logic [1:0]  r_cuenta;

   assign palabra       = {r_bytes, byte_in};
   assign palabra_lista = desplazar && (r_cuenta == C_ULTIMO);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_bytes  <= '0;
         r_cuenta <= '0;
      end else if (limpiar) begin
         r_bytes  <= '0;
         r_cuenta <= '0;
      end else if (desplazar) begin
         r_bytes  <= palabra[23:0];
         r_cuenta <= r_cuenta + 2'd1;   // wraps to 0 after the 4th byte
      end
   end

endmodule

// File: rtl/cargador_instrucciones.sv
// Loads a byte stream into instruction memory as big-endian words, then releases the CPU.
// Latency: 4 byte transfers + 1 write cycle per word; release the cycle after the last write.
// Backpressure: byte_ready is high only while collecting bytes (state decode, registered).
//
// Ports:
//   CLK, RST_N          clock, async active-low reset
//   inicio/num_palabras start request and word count (sampled together)
//   byte_in/byte_valid/byte_ready  byte stream handshake
//   mem_we/mem_dir/mem_dato        instruction memory write port
//   pc_rst              one-cycle PC clear on release
//   cpu_run             processor enable, held while running
//   err_rango           sticky: a request exceeded PROF_MEM
module cargador_instrucciones
   import pkg_cargador::*;
#(
   parameter int PROF_MEM = PROF_MEM_DEF,
   parameter int ANCHO_N  = 7
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               inicio,
   input  logic [ANCHO_N-1:0] num_palabras,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic               mem_we,
   output logic [31:0]        mem_dir,
   output logic [31:0]        mem_dato,
   output logic               pc_rst,
   output logic               cpu_run,
   output logic               err_rango
);

   localparam logic [ANCHO_N-1:0] C_PROF = ANCHO_N'(PROF_MEM);
   localparam logic [ANCHO_N-1:0] C_UNO  = ANCHO_N'(1);
   localparam logic [ANCHO_N-1:0] C_CERO = '0;

   estado_t            r_estado;
   logic [ANCHO_N-1:0] r_indice;
   logic [ANCHO_N-1:0] r_objetivo;
   logic               r_byte_ready;
   logic               r_mem_we;
   logic [31:0]        r_mem_dir;
   logic [31:0]        r_mem_dato;
   logic               r_pc_rst;
   logic               r_cpu_run;
   logic               r_err_rango;

   logic               w_desplazar;
   logic               w_limpiar;
   logic               w_lista;
   logic [31:0]        w_palabra;
   logic [ANCHO_N-1:0] w_indice_sig;

   // r_byte_ready mirrors (state == CARGA), so a transfer is simply valid & ready.
   assign w_desplazar  = r_byte_ready && byte_valid;
   assign w_limpiar    = inicio && ((r_estado == REPOSO) || (r_estado == EJECUCION));
   assign w_indice_sig = r_indice + C_UNO;

   ensamblador_palabra u_ensamblador (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .desplazar     (w_desplazar),
      .limpiar       (w_limpiar),
      .byte_in       (byte_in),
      .palabra       (w_palabra),
      .palabra_lista (w_lista)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_estado     <= REPOSO;
         r_indice     <= '0;
         r_objetivo   <= '0;
         r_byte_ready <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_dir    <= '0;
         r_mem_dato   <= '0;
         r_pc_rst     <= 1'b0;
         r_cpu_run    <= 1'b0;
         r_err_rango  <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         r_pc_rst <= 1'b0;
         case (r_estado)
            REPOSO, EJECUCION: begin
               if (inicio) begin
                  r_indice <= '0;
                  if (num_palabras == C_CERO) begin
                     // Nothing to load: (re)start the processor straight away.
                     r_estado     <= EJECUCION;
                     r_byte_ready <= 1'b0;
                     r_pc_rst     <= 1'b1;
                     r_cpu_run    <= 1'b1;
                  end else begin
                     r_estado     <= CARGA;
                     r_byte_ready <= 1'b1;
                     r_cpu_run    <= 1'b0;
                     if (num_palabras > C_PROF) begin
                        r_objetivo  <= C_PROF;
                        r_err_rango <= 1'b1;
                     end else begin
                        r_objetivo  <= num_palabras;
                     end
                  end
               end
            end
            CARGA: begin
               if (w_lista) begin
                  r_estado     <= ESCRITURA;
                  r_byte_ready <= 1'b0;
                  r_mem_we     <= 1'b1;
                  r_mem_dir    <= 32'({r_indice, 2'b00});
                  r_mem_dato   <= w_palabra;
               end
            end
            ESCRITURA: begin
               r_indice <= w_indice_sig;
               if (w_indice_sig == r_objetivo) begin
                  r_estado  <= EJECUCION;
                  r_pc_rst  <= 1'b1;
                  r_cpu_run <= 1'b1;
               end else begin
                  r_estado     <= CARGA;
                  r_byte_ready <= 1'b1;
               end
            end
            default: begin
               r_estado     <= REPOSO;
               r_byte_ready <= 1'b0;
            end
         endcase
      end
   end

   assign byte_ready = r_byte_ready;
   assign mem_we     = r_mem_we;
   assign mem_dir    = r_mem_dir;
   assign mem_dato   = r_mem_dato;
   assign pc_rst     = r_pc_rst;
   assign cpu_run    = r_cpu_run;
   assign err_rango  = r_err_rango;

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Directed bench for cargador_instrucciones: table of words plus corner-case sequences.
// Latency: n/a.
// Backpressure: the byte source only advances when byte_valid & byte_ready met at an edge.
module tb_cargador_instrucciones;

   localparam int AN = 7;

   logic          CLK;
   logic          RST_N;
   logic          inicio;
   logic [AN-1:0] num_palabras;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic          mem_we;
   logic [31:0]   mem_dir;
   logic [31:0]   mem_dato;
   logic          pc_rst;
   logic          cpu_run;
   logic          err_rango;

   cargador_instrucciones #(.PROF_MEM(64), .ANCHO_N(AN)) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .inicio       (inicio),
      .num_palabras (num_palabras),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .mem_we       (mem_we),
      .mem_dir      (mem_dir),
      .mem_dato     (mem_dato),
      .pc_rst       (pc_rst),
      .cpu_run      (cpu_run),
      .err_rango    (err_rango)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int first_cyc = 0;
   int pc_cyc    = 0;
   int pc_cnt    = 0;
   logic [31:0] wr_dir[$];
   logic [31:0] wr_dat[$];

   always @(posedge CLK) cyc <= cyc + 1;

   // Write/pulse monitor, sampled mid-cycle.
   always @(negedge CLK) begin
      if (mem_we) begin
         wr_dir.push_back(mem_dir);
         wr_dat.push_back(mem_dato);
      end
      if (pc_rst) begin
         pc_cnt = pc_cnt + 1;
         pc_cyc = cyc;
      end
   end

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] dir;
      logic [31:0] dato;
   } vec_t;
   vec_t tabla[4];

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nombre, act, exp);
      end
   endtask

   task automatic limpiar_log();
      wr_dir.delete();
      wr_dat.delete();
      pc_cnt = 0;
   endtask

   task automatic arrancar(input int n);
      inicio       = 1'b1;
      num_palabras = AN'(n);
      @(negedge CLK);
      inicio       = 1'b0;
   endtask

   // Offer bytes from q; gap=1 drops byte_valid every other cycle.
   task automatic enviar(input logic [7:0] q[$], input bit gap);
      int i = 0;
      int t = 0;
      bit fase = 1'b1;
      bit xfer;
      while (i < q.size() && t < 8 * q.size() + 40) begin
         byte_valid = gap ? fase : 1'b1;
         fase       = ~fase;
         byte_in    = q[i];
         // Outside the write cycle the loader must be ready.
         if (byte_ready === mem_we) chk("ready_en_carga", {31'd0, byte_ready}, {31'd0, ~mem_we});
         xfer = byte_valid && byte_ready;
         @(negedge CLK);
         t++;
         if (xfer) begin
            if (i == 0) first_cyc = cyc;
            i++;
         end
      end
      byte_valid = 1'b0;
      if (i < q.size()) chk("stream_timeout", 32'(i), 32'(q.size()));
   endtask

   task automatic esperar_run();
      int t = 0;
      while (!cpu_run && t < 50) begin
         @(negedge CLK);
         t++;
      end
      chk("release", {31'd0, cpu_run}, 32'd1);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      logic [7:0] q[$];

      tabla[0] = '{8'h00, 8'h22, 8'h18, 8'h20, 32'h0, 32'h00221820};
      tabla[1] = '{8'h8C, 8'h01, 8'h00, 8'h04, 32'h4, 32'h8C010004};
      tabla[2] = '{8'hAC, 8'h43, 8'h00, 8'h08, 32'h8, 32'hAC430008};
      tabla[3] = '{8'h10, 8'h00, 8'hFF, 8'hFE, 32'hC, 32'h1000FFFE};

      RST_N = 1'b0; inicio = 1'b0; num_palabras = '0; byte_in = '0; byte_valid = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_cpu_run",    {31'd0, cpu_run},    32'd0);
      chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      chk("rst_mem_we",     {31'd0, mem_we},     32'd0);
      chk("rst_err_rango",  {31'd0, err_rango},  32'd0);
      chk("rst_pc_rst",     {31'd0, pc_rst},     32'd0);
      RST_N = 1'b1;
      @(negedge CLK);

      // N=0: straight to EJECUCION, no write.
      limpiar_log();
      arrancar(0);
      chk("n0_pc_rst",  {31'd0, pc_rst},  32'd1);
      chk("n0_cpu_run", {31'd0, cpu_run}, 32'd1);
      @(negedge CLK);
      chk("n0_pc_rst_pulse", {31'd0, pc_rst}, 32'd0);
      repeat (3) @(negedge CLK);
      chk("n0_writes", 32'(wr_dir.size()), 32'd0);
      chk("n0_cpu_hold", {31'd0, cpu_run}, 32'd1);

      // Table load, reloaded from EJECUCION, bytes offered every cycle.
      limpiar_log();
      arrancar(4);
      chk("reload_cpu_drop", {31'd0, cpu_run},    32'd0);
      chk("reload_ready",    {31'd0, byte_ready}, 32'd1);
      q.delete();
      for (int k = 0; k < 4; k++) begin
         q.push_back(tabla[k].b0); q.push_back(tabla[k].b1);
         q.push_back(tabla[k].b2); q.push_back(tabla[k].b3);
      end
      enviar(q, 1'b0);
      esperar_run();
      chk("tab_writes", 32'(wr_dir.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < wr_dir.size()) begin
            chk($sformatf("tab_dir%0d", k),  wr_dir[k], tabla[k].dir);
            chk($sformatf("tab_dato%0d", k), wr_dat[k], tabla[k].dato);
         end
      end
      chk("tab_pc_pulses", 32'(pc_cnt), 32'd1);
      chk("tab_pc_timing", 32'(pc_cyc - first_cyc), 32'd19);
      chk("tab_cpu_hold",  {31'd0, cpu_run}, 32'd1);
      chk("tab_dato_hold", mem_dato, 32'h1000FFFE);

      // N=1 with gapped valid.
      limpiar_log();
      arrancar(1);
      q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      enviar(q, 1'b1);
      esperar_run();
      chk("gap_writes", 32'(wr_dir.size()), 32'd1);
      if (wr_dir.size() > 0) begin
         chk("gap_dir",  wr_dir[0], 32'h0);
         chk("gap_dato", wr_dat[0], 32'hDEADBEEF);
      end
      chk("gap_pc_pulses", 32'(pc_cnt), 32'd1);

      // Reset in the middle of word 1.
      limpiar_log();
      arrancar(2);
      q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      enviar(q, 1'b0);
      repeat (1) @(negedge CLK);
      chk("mid_writes", 32'(wr_dir.size()), 32'd1);
      RST_N = 1'b0;
      #1;
      chk("mid_rst_outs", {26'd0, byte_ready, mem_we, pc_rst, cpu_run, err_rango, 1'b0}, 32'd0);
      chk("mid_rst_dato", mem_dato, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      limpiar_log();
      arrancar(1);
      q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      enviar(q, 1'b0);
      esperar_run();
      chk("fresh_writes", 32'(wr_dir.size()), 32'd1);
      if (wr_dir.size() > 0) begin
         chk("fresh_dir",  wr_dir[0], 32'h0);
         chk("fresh_dato", wr_dat[0], 32'hA1B2C3D4);
      end
      chk("fresh_err", {31'd0, err_rango}, 32'd0);

      // N=100 clamps to 64 words.
      limpiar_log();
      arrancar(100);
      chk("clamp_err", {31'd0, err_rango}, 32'd1);
      q.delete();
      for (int j = 0; j < 256; j++) q.push_back(8'(j));
      enviar(q, 1'b0);
      esperar_run();
      chk("clamp_writes", 32'(wr_dir.size()), 32'd64);
      if (wr_dir.size() == 64) begin
         chk("clamp_first_dato", wr_dat[0],  32'h00010203);
         chk("clamp_last_dir",   wr_dir[63], 32'h000000FC);
         chk("clamp_last_dato",  wr_dat[63], 32'hFCFDFEFF);
      end
      chk("clamp_err_sticky", {31'd0, err_rango}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
